// File: rtl/path_delay_meter.sv
// Measures the round-trip delay of an external path by launching alternating edges
// and counting synchronized clock cycles until the edge returns, over TRIALS launches.
module path_delay_meter #(
  parameter int TRIALS  = 16,
  parameter int TIMEOUT = 1023,
  parameter int SETTLE  = 8,
  parameter int CNT_W   = 10,
  parameter int SUM_W   = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             path_result,
  output logic             path_launch,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic [SUM_W-1:0] delay_sum,
  output logic [CNT_W-1:0] delay_min,
  output logic [CNT_W-1:0] delay_max
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_ACCUM   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               sync_meta_q, sync_meta_d;
  logic               sync_result_q, sync_result_d;
  logic               launch_q, launch_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               terr_q, terr_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   min_q, min_d;
  logic [CNT_W-1:0]   max_q, max_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         trial_q, trial_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [SUM_W:0]     sum_ext_s;

  always_comb begin
    state_d       = state_q;
    sync_meta_d   = path_result;
    sync_result_d = sync_meta_q;
    launch_d      = launch_q;
    terr_d        = terr_q;
    sum_d         = sum_q;
    min_d         = min_q;
    max_d         = max_q;
    cnt_d         = cnt_q;
    trial_d       = trial_q;
    settle_d      = settle_q;
    sum_ext_s     = {1'b0, sum_q} + {{(SUM_W + 1 - CNT_W){1'b0}}, cnt_q};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          sum_d    = '0;
          max_d    = '0;
          min_d    = '1;
          terr_d   = 1'b0;
          trial_d  = 8'd0;
          settle_d = '0;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SET_W'(SETTLE - 1)) begin
          state_d = ST_LAUNCH;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      ST_LAUNCH: begin
        launch_d = ~launch_q;
        cnt_d    = '0;
        state_d  = ST_MEASURE;
      end
      ST_MEASURE: begin
        // cnt_q is left untouched on a match so ACCUM sees the latched count
        if (sync_result_q == launch_q) begin
          state_d = ST_ACCUM;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          terr_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACCUM: begin
        sum_d   = sum_ext_s[SUM_W] ? '1 : sum_ext_s[SUM_W-1:0];
        min_d   = (cnt_q < min_q) ? cnt_q : min_q;
        max_d   = (cnt_q > max_q) ? cnt_q : max_q;
        trial_d = trial_q + 8'd1;
        if ((trial_q + 8'd1) == 8'(TRIALS)) begin
          state_d = ST_DONE;
        end else begin
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy/done are registered, so they are derived from the state being entered
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sync_meta_q   <= 1'b0;
      sync_result_q <= 1'b0;
      launch_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      terr_q        <= 1'b0;
      sum_q         <= '0;
      min_q         <= '0;
      max_q         <= '0;
      cnt_q         <= '0;
      trial_q       <= 8'd0;
      settle_q      <= '0;
    end else begin
      state_q       <= state_d;
      sync_meta_q   <= sync_meta_d;
      sync_result_q <= sync_result_d;
      launch_q      <= launch_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      terr_q        <= terr_d;
      sum_q         <= sum_d;
      min_q         <= min_d;
      max_q         <= max_d;
      cnt_q         <= cnt_d;
      trial_q       <= trial_d;
      settle_q      <= settle_d;
    end
  end

  assign path_launch = launch_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign delay_sum   = sum_q;
  assign delay_min   = min_q;
  assign delay_max   = max_q;

endmodule

// File: tb/tb_path_delay_meter.sv
// Directed bench for path_delay_meter: a scoreboard queue holds the expected result
// of each measurement, popped and compared when done pulses.
module tb_path_delay_meter;

  localparam int TRIALS  = 4;
  localparam int TIMEOUT = 15;
  localparam int SETTLE  = 3;
  localparam int CNT_W   = 4;
  localparam int SUM_W   = 10;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] mn;
    logic [CNT_W-1:0] mx;
    logic             terr;
    logic             launch;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             path_result;
  logic             path_launch;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic [SUM_W-1:0] delay_sum;
  logic [CNT_W-1:0] delay_min;
  logic [CNT_W-1:0] delay_max;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   done_cnt = 0;
  int   mode    = 0;   // 0 loopback, 1 three-register delay, 2 rise 0 / fall +2, 3 stuck at 0
  logic [2:0] dly_q = 3'b000;
  exp_t sb[$];

  path_delay_meter #(
    .TRIALS(TRIALS), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE), .CNT_W(CNT_W), .SUM_W(SUM_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .path_result(path_result),
    .path_launch(path_launch), .busy(busy), .done(done), .timeout_err(timeout_err),
    .delay_sum(delay_sum), .delay_min(delay_min), .delay_max(delay_max)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    dly_q <= {dly_q[1:0], path_launch};
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Model of the external path under test
  always_comb begin
    case (mode)
      0:       path_result = path_launch;
      1:       path_result = dly_q[2];
      2:       path_result = path_launch | dly_q[1];
      default: path_result = 1'b0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_launch"}, {31'd0, path_launch}, 32'd0);
    check({tag, "_busy"},   {31'd0, busy},        32'd0);
    check({tag, "_done"},   {31'd0, done},        32'd0);
    check({tag, "_terr"},   {31'd0, timeout_err}, 32'd0);
    check({tag, "_sum"},    32'(delay_sum),       32'd0);
    check({tag, "_min"},    32'(delay_min),       32'd0);
    check({tag, "_max"},    32'(delay_max),       32'd0);
  endtask

  // Runs one measurement; lat is cycles from the first launch edge to done
  task automatic run_meas(input string tag, input exp_t e, output int lat);
    bit   ok;
    bit   seen;
    int   t0;
    int   n;
    logic l0;
    exp_t got;
    ok   = 1'b0;
    seen = 1'b0;
    t0   = 0;
    n    = 0;
    lat  = -1;
    l0   = path_launch;
    sb.push_back(e);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    while (!ok && n < 400) begin
      @(negedge clk);
      n++;
      if (!seen && path_launch !== l0) begin
        seen = 1'b1;
        t0   = cyc;
      end
      if (done === 1'b1) ok = 1'b1;
    end
    check({tag, "_done_seen"}, {31'd0, ok}, 32'd1);
    lat = cyc - t0;
    got = sb.pop_front();
    check({tag, "_sum"},    32'(delay_sum),         32'(got.sum));
    check({tag, "_min"},    32'(delay_min),         32'(got.mn));
    check({tag, "_max"},    32'(delay_max),         32'(got.mx));
    check({tag, "_terr"},   {31'd0, timeout_err},   {31'd0, got.terr});
    check({tag, "_launch"}, {31'd0, path_launch},   {31'd0, got.launch});
    check({tag, "_busy_in_done"}, {31'd0, busy},    32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_done_one_cycle"}, {31'd0, done},  32'd0);
    check({tag, "_sum_hold"},  32'(delay_sum),       32'(got.sum));
    check({tag, "_terr_hold"}, {31'd0, timeout_err}, {31'd0, got.terr});
  endtask

  initial begin
    int   lat;
    int   d0;
    int   n;
    logic l0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    mode = 0;
    run_meas("loopback", '{sum: 10'd8, mn: 4'd2, mx: 4'd2, terr: 1'b0, launch: 1'b0}, lat);

    mode = 1;
    repeat (4) @(negedge clk);
    run_meas("delay3", '{sum: 10'd20, mn: 4'd5, mx: 4'd5, terr: 1'b0, launch: 1'b0}, lat);

    mode = 2;
    repeat (4) @(negedge clk);
    run_meas("alt_0_2", '{sum: 10'd12, mn: 4'd2, mx: 4'd4, terr: 1'b0, launch: 1'b0}, lat);

    // Starts while busy and in the DONE cycle must be ignored
    mode = 0;
    repeat (4) @(negedge clk);
    d0 = done_cnt;
    sb.push_back('{sum: 10'd8, mn: 4'd2, mx: 4'd2, terr: 1'b0, launch: 1'b0});
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ignore_done_seen", {31'd0, done}, 32'd1);
    begin
      exp_t got;
      got = sb.pop_front();
      check("ignore_sum", 32'(delay_sum), 32'(got.sum));
      check("ignore_min", 32'(delay_min), 32'(got.mn));
      check("ignore_max", 32'(delay_max), 32'(got.mx));
    end
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("ignore_start_in_done_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    check("ignore_still_idle", {31'd0, busy}, 32'd0);
    check("ignore_one_done", done_cnt - d0, 32'd1);

    // Stuck path: the first (rising) trial times out
    mode = 3;
    repeat (4) @(negedge clk);
    run_meas("timeout", '{sum: 10'd0, mn: 4'hF, mx: 4'd0, terr: 1'b1, launch: 1'b1}, lat);
    check("timeout_latency", lat, TIMEOUT + 1);

    // Reset during MEASURE of the second trial
    mode = 0;
    repeat (4) @(negedge clk);
    l0 = path_launch;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (path_launch === l0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (path_launch !== l0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reached_trial2", {31'd0, busy}, 32'd1);
    d0  = done_cnt;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_reset_outputs("midrst");
    repeat (30) @(negedge clk);
    check("midrst_no_done", done_cnt, d0);
    check("midrst_stays_idle", {31'd0, busy}, 32'd0);
    run_meas("after_rst", '{sum: 10'd8, mn: 4'd2, mx: 4'd2, terr: 1'b0, launch: 1'b0}, lat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
